// File: rtl/sa_pkg.sv
// Shared definitions for the simulated-annealing core: FSM encoding,
// LFSR polynomial and probability fixed-point format.
package sa_pkg;

    // Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    // Probability is unsigned Q8.24, so 1.0 sits at bit 24
    localparam logic [31:0] PROB_ONE       = 32'h0100_0000;
    localparam int          PROB_FRAC_BITS = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } sa_state_e;

    // One right-shifting Galois step; bit 0 falls out and feeds back via the taps
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// Free-running 32-bit Galois LFSR. A zero seed would lock the register,
// so it is substituted with 1.
module lfsr32
    import sa_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] state
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] r_state;

    // Load the seed in reset, otherwise advance one step every cycle
    always_ff @(posedge clk) begin
        if (!rst) r_state <= SEED_EFF;
        else      r_state <= lfsr_next(r_state);
    end

    assign state = r_state;

endmodule

// File: rtl/sa_accept_decider.sv
// Metropolis accept/reject stage. Downhill/equal moves are accepted
// straight away; uphill moves ask the probability computer and compare
// its answer with the LFSR, with a bounded wait ending in a forced reject.
module sa_accept_decider
    import sa_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h1D87_2B41,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cand_valid,
    output logic        cand_ready,
    input  logic [31:0] new_cost,
    input  logic [31:0] old_cost,
    output logic        pc_req_valid,
    output logic [31:0] pc_new,
    output logic [31:0] pc_old,
    input  logic [31:0] pc_prob,
    input  logic        pc_prob_valid,
    output logic        dec_valid,
    output logic        dec_accept,
    output logic        dec_downhill,
    output logic        dec_timeout,
    output logic [31:0] accept_cnt,
    output logic [31:0] reject_cnt
);

    localparam int          CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    sa_state_e   r_state;
    logic [CW-1:0] r_wait;
    logic [31:0] r_pc_new;
    logic [31:0] r_pc_old;
    logic        r_acc;
    logic        r_down;
    logic        r_to;
    logic [31:0] r_acc_cnt;
    logic [31:0] r_rej_cnt;

    logic [31:0] w_lfsr;
    logic        w_prob_acc;

    lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (w_lfsr)
    );

    // Any integer part means p >= 1.0 and the move is always taken;
    // otherwise the fractional bits race a uniform 24-bit sample.
    assign w_prob_acc = (pc_prob[31:PROB_FRAC_BITS] != '0) ||
                        (w_lfsr[PROB_FRAC_BITS-1:0] < pc_prob[PROB_FRAC_BITS-1:0]);

    // Decision FSM with wait counter and statistics
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_pc_new  <= '0;
            r_pc_old  <= '0;
            r_acc     <= 1'b0;
            r_down    <= 1'b0;
            r_to      <= 1'b0;
            r_acc_cnt <= '0;
            r_rej_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cand_valid) begin
                        r_pc_new <= new_cost;
                        r_pc_old <= old_cost;
                        r_to     <= 1'b0;
                        if (new_cost <= old_cost) begin
                            r_acc   <= 1'b1;
                            r_down  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_acc   <= 1'b0;
                            r_down  <= 1'b0;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    r_wait  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    // A response landing on the last wait cycle still wins
                    if (pc_prob_valid) begin
                        r_acc   <= w_prob_acc;
                        r_to    <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_acc   <= 1'b0;
                        r_to    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_acc) r_acc_cnt <= r_acc_cnt + 32'd1;
                    else       r_rej_cnt <= r_rej_cnt + 32'd1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cand_ready   = rst && (r_state == ST_IDLE);
    assign pc_req_valid = (r_state == ST_REQ);
    assign pc_new       = r_pc_new;
    assign pc_old       = r_pc_old;
    assign dec_valid    = (r_state == ST_DONE);
    assign dec_accept   = dec_valid && r_acc;
    assign dec_downhill = dec_valid && r_down;
    assign dec_timeout  = dec_valid && r_to;
    assign accept_cnt   = r_acc_cnt;
    assign reject_cnt   = r_rej_cnt;

endmodule

// File: tb/tb_sa_accept_decider.sv
// Bench for sa_accept_decider: table of directed candidates, hand-written
// timeout/late-response/reset sequences, then randomized and statistical runs
// against a behavioural model (cost compare, Q8.24 threshold, reference LFSR).
module tb_sa_accept_decider;

    localparam logic [31:0] SEED = 32'h1D87_2B41;
    localparam int          TO   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cand_valid = 1'b0;
    logic        cand_ready;
    logic [31:0] new_cost = '0;
    logic [31:0] old_cost = '0;
    logic        pc_req_valid;
    logic [31:0] pc_new, pc_old;
    logic [31:0] pc_prob = '0;
    logic        pc_prob_valid = 1'b0;
    logic        dec_valid, dec_accept, dec_downhill, dec_timeout;
    logic [31:0] accept_cnt, reject_cnt;

    sa_accept_decider #(.LFSR_SEED(SEED), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cand_valid   (cand_valid),
        .cand_ready   (cand_ready),
        .new_cost     (new_cost),
        .old_cost     (old_cost),
        .pc_req_valid (pc_req_valid),
        .pc_new       (pc_new),
        .pc_old       (pc_old),
        .pc_prob      (pc_prob),
        .pc_prob_valid(pc_prob_valid),
        .dec_valid    (dec_valid),
        .dec_accept   (dec_accept),
        .dec_downhill (dec_downhill),
        .dec_timeout  (dec_timeout),
        .accept_cnt   (accept_cnt),
        .reject_cnt   (reject_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_rej = '0;
    logic [31:0] m_lfsr;

    // Reference sequence generator: polynomial x^32+x^22+x^2+x+1,
    // multiply-by-x^-1 form, restarting at the seed whenever rst is sampled low
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= (m_lfsr >> 1) ^ ({32{m_lfsr[0]}} & 32'h8020_0003);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one candidate; respond k cycles after the request (k=0: never).
    // exp_a: 0/1 fixed expectation, 2 = take it from the model only.
    task automatic do_cand(input logic [31:0] nc, input logic [31:0] oc, input int k,
                           input logic [31:0] prob, input int exp_a, input string nm,
                           output logic got_acc);
        logic down, ea, et;
        int   cyc, nreq, lat;
        down = (nc <= oc);
        chk({nm, " ready"}, {31'b0, cand_ready}, 32'd1);
        cand_valid = 1'b1; new_cost = nc; old_cost = oc;
        tick;
        cand_valid = 1'b0; new_cost = $urandom; old_cost = $urandom;
        cyc = 1; nreq = 0; ea = down; et = 1'b0;
        if (!down) begin ea = 1'b0; et = (k == 0); end
        while (!dec_valid && cyc < 200) begin
            if (pc_req_valid) nreq++;
            if (!down && cyc == 1) begin
                chk({nm, " pc_new"}, pc_new, nc);
                chk({nm, " pc_old"}, pc_old, oc);
                // stray response while still in REQ must be ignored
                pc_prob_valid = 1'b1; pc_prob = 32'h0F00_0000;
            end else if (!down && k > 0 && cyc == 1 + k) begin
                pc_prob_valid = 1'b1; pc_prob = prob;
                ea = (prob >= 32'h0100_0000) || (m_lfsr[23:0] < prob[23:0]);
            end else begin
                pc_prob_valid = 1'b0; pc_prob = $urandom;
            end
            tick;
            cyc++;
        end
        pc_prob_valid = 1'b0;
        lat = down ? 1 : ((k > 0) ? 2 + k : 2 + TO);
        chk({nm, " latency"}, cyc, lat);
        chk({nm, " dec_valid"}, {31'b0, dec_valid}, 32'd1);
        chk({nm, " accept"}, {31'b0, dec_accept}, {31'b0, ea});
        if (exp_a != 2) chk({nm, " accept_tab"}, {31'b0, dec_accept}, exp_a);
        chk({nm, " downhill"}, {31'b0, dec_downhill}, {31'b0, down});
        chk({nm, " timeout"}, {31'b0, dec_timeout}, {31'b0, et});
        chk({nm, " nreq"}, nreq, down ? 0 : 1);
        chk({nm, " pc_new_hold"}, pc_new, nc);
        got_acc = dec_accept;
        if (ea) m_acc++; else m_rej++;
        tick;
        chk({nm, " dec_valid_off"}, {31'b0, dec_valid}, 32'd0);
        chk({nm, " accept_cnt"}, accept_cnt, m_acc);
        chk({nm, " reject_cnt"}, reject_cnt, m_rej);
    endtask

    typedef struct {
        logic [31:0] nc;
        logic [31:0] oc;
        int          k;
        logic [31:0] prob;
        int          exp_a;
        string       nm;
    } vec_t;

    vec_t tab[8];

    initial begin
        logic a;
        int   nacc, pulses;

        tab[0] = '{32'd100, 32'd150, 0, 32'h0, 1, "downhill"};
        tab[1] = '{32'd42, 32'd42, 0, 32'h0, 1, "equal"};
        tab[2] = '{32'd200, 32'd100, 3, 32'h00FF_FFFF, 2, "up_hi"};
        tab[3] = '{32'd200, 32'd100, 2, 32'h0, 0, "up_zero"};
        tab[4] = '{32'd200, 32'd100, 1, 32'h0100_0000, 1, "up_one"};
        tab[5] = '{32'd0, 32'hFFFF_FFFF, 0, 32'h0, 1, "down_max"};
        tab[6] = '{32'hFFFF_FFFF, 32'd0, TO, 32'h0200_0000, 1, "resp_at_to"};
        tab[7] = '{32'd5, 32'd4, 0, 32'h0, 0, "timeout"};

        // reset state
        repeat (3) tick;
        chk("rst cand_ready", {31'b0, cand_ready}, 32'd0);
        chk("rst dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst pc_req", {31'b0, pc_req_valid}, 32'd0);
        chk("rst pc_new", pc_new, 32'd0);
        chk("rst accept_cnt", accept_cnt, 32'd0);
        chk("rst reject_cnt", reject_cnt, 32'd0);
        chk("rst lfsr", dut.u_lfsr.state, SEED);
        rst = 1'b1;
        tick;

        foreach (tab[i]) do_cand(tab[i].nc, tab[i].oc, tab[i].k, tab[i].prob, tab[i].exp_a, tab[i].nm, a);

        // late response after a timeout lands in IDLE and is ignored
        do_cand(32'd7, 32'd3, 0, 32'h0, 0, "to2", a);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            pc_prob_valid = 1'b1; pc_prob = 32'h0F00_0000;
            tick;
            if (dec_valid) pulses++;
        end
        pc_prob_valid = 1'b0;
        chk("late pulses", pulses, 0);
        chk("late accept_cnt", accept_cnt, m_acc);
        chk("late reject_cnt", reject_cnt, m_rej);

        // reset while waiting for the probability computer
        cand_valid = 1'b1; new_cost = 32'd900; old_cost = 32'd10;
        tick;
        cand_valid = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("midrst dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("midrst cand_ready", {31'b0, cand_ready}, 32'd0);
        chk("midrst pc_new", pc_new, 32'd0);
        chk("midrst pc_old", pc_old, 32'd0);
        chk("midrst accept_cnt", accept_cnt, 32'd0);
        chk("midrst reject_cnt", reject_cnt, 32'd0);
        chk("midrst lfsr", dut.u_lfsr.state, m_lfsr);
        chk("midrst lfsr_seed", dut.u_lfsr.state, SEED);
        rst = 1'b1;
        m_acc = '0; m_rej = '0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            pc_prob_valid = 1'b1; pc_prob = 32'h0F00_0000;
            tick;
            if (dec_valid || pc_req_valid) pulses++;
        end
        pc_prob_valid = 1'b0;
        chk("midrst no_pulse", pulses, 0);
        do_cand(32'd1, 32'd2, 0, 32'h0, 1, "post_rst", a);

        // clamp at 1.0
        nacc = 0;
        for (int i = 0; i < 100; i++) begin
            do_cand(32'd300 + i, 32'd1, 1 + (i % 3), 32'h0100_0000, 1, "clamp", a);
            nacc += int'(a);
        end
        chk("clamp total", nacc, 100);

        // randomized mix against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rn, ro, rp;
            int rk;
            rn = $urandom; ro = $urandom;
            if ($urandom_range(0, 3) == 0) ro = rn;
            rk = $urandom_range(0, TO);
            rp = ($urandom_range(0, 7) == 0) ? $urandom : {8'h0, 24'($urandom)};
            do_cand(rn, ro, rk, rp, 2, "rand", a);
        end

        // acceptance rate at p = 0.5
        nacc = 0;
        for (int i = 0; i < 10000; i++) begin
            do_cand(32'd20, 32'd10, 1, 32'h0080_0000, 2, "stat", a);
            nacc += int'(a);
        end
        chk("stat rate_in_band", {31'b0, (nacc >= 4800 && nacc <= 5200)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_accept_decider.md
# sa_accept_decider

Metropolis accept/reject stage of the simulated-annealing core, directly downstream of the probability computer. Takes a candidate move's new and old tour costs and accepts downhill or equal-cost moves immediately. For uphill moves it drives the probability computer, then compares the returned acceptance probability against an internal free-running LFSR. It emits a one-cycle decision pulse to the swap/commit logic and keeps accept/reject statistics.

## Interface
Parameters:
- LFSR_SEED, 32'h1D87_2B41, LFSR reset value; a value of 0 is replaced by 32'h1.
- TIMEOUT, 64, maximum cycles spent in WAIT before a forced reject; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- cand_valid  in  1  candidate present.
- cand_ready  out  1  block can take a candidate.
- new_cost  in  32  unsigned cost after move.
- old_cost  in  32  unsigned cost before move.
- pc_req_valid  out  1  one-cycle request to the probability computer's inp_valid.
- pc_new  out  32  registered new_cost, to the probability computer.
- pc_old  out  32  registered old_cost, to the probability computer.
- pc_prob  in  32  probability, unsigned Q8.24 (1.0 = 32'h0100_0000).
- pc_prob_valid  in  1  pc_prob is valid this cycle.
- dec_valid  out  1  one-cycle decision strobe.
- dec_accept  out  1  move accepted; valid with dec_valid.
- dec_downhill  out  1  accepted without a probability test.
- dec_timeout  out  1  rejected because no response arrived within TIMEOUT cycles.
- accept_cnt  out  32  total accepts, wraps.
- reject_cnt  out  32  total rejects, wraps.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - cand_ready = 1 while rst is high.
  - On cand_valid: latch the costs into pc_new/pc_old.
  - If new_cost ≤ old_cost (unsigned): go to DONE with accept=1, downhill=1.
  - Otherwise: go to REQ.
- REQ
  - pc_req_valid = 1 for exactly this cycle.
  - Clear the wait counter, then go to WAIT.
- WAIT
  - The wait counter increments every cycle.
  - If pc_prob_valid: accept = (pc_prob[31:24] ≠ 0) OR (lfsr[23:0] < pc_prob[23:0]), using the LFSR value of that same cycle. Go to DONE.
  - Else if the counter = TIMEOUT−1: accept=0, timeout=1, go to DONE.
  - pc_prob_valid and timeout in the same cycle: the response wins.
- DONE
  - dec_valid = 1; dec_accept, dec_downhill and dec_timeout come from registered flags.
  - Increment accept_cnt or reject_cnt.
  - Go to IDLE.
- pc_prob_valid outside WAIT (for example a late response after a timeout) is ignored.
- LFSR: 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), shifts every cycle in every state. It is never all-zero.
- Counters wrap from 32'hFFFF_FFFF to 0.
- No decision backpressure: the consumer must sample the dec_* outputs during dec_valid.

## Timing
- Reset (rst low at a clock edge): state=IDLE and LFSR=seed.
  - Reset to 0: every output and counter.
  - cand_ready = 0 while rst is low.
  - A reset mid-operation abandons the candidate with no decision pulse.
- Candidate handshake at edge t0.
- Downhill path: dec_valid is high in cycle t0+1, so the latency is 1.
- Uphill path:
  - pc_req_valid is high in cycle t0+1.
  - pc_new/pc_old are stable from t0+1 until the return to IDLE.
  - A response first seen in cycle t0+1+k (k ≥ 1) gives dec_valid in cycle t0+2+k.
- Timeout path: dec_valid in cycle t0+2+TIMEOUT.
- Throughput: a new candidate can be accepted in the cycle after dec_valid.
- Counters update at the DONE edge and are visible one cycle after dec_valid.

## Structure
- Shared package sa_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - LFSR_TAPS = 32'h8020_0003;
  - PROB_ONE = 32'h0100_0000;
  - PROB_FRAC_BITS = 24.
- One sub-module, lfsr32: inputs clk, rst and a seed parameter; output state[31:0]. It is reusable by the move generator.
- FSM, compare, wait counter and statistics counters stay in sa_accept_decider.

## Test plan
- Downhill: new=100, old=150 → dec_valid at t0+1 with accept=1, downhill=1; pc_req_valid never asserted; accept_cnt=1.
- Equal cost: new=old=42 → accepted as downhill, no request issued.
- Uphill accept and reject:
  - new=200, old=100, pc_prob=32'h00FF_FFFF returned 3 cycles after the request → accept=1, dec_valid at t0+5.
  - pc_prob=0 → accept=0, reject_cnt increments.
- Clamp: pc_prob=32'h0100_0000 → always accept across 100 trials.
  - Statistics: pc_prob=32'h0080_0000 over 10 000 trials → accept rate 0.5 ± 0.02.
- Timeout: TIMEOUT=8 with no response → dec_valid at t0+10, accept=0, dec_timeout=1. A late pc_prob_valid in IDLE is ignored and the counters are unchanged.
- Reset during WAIT: no dec_valid pulse; all outputs are 0; the LFSR restarts at the seed value (matched against a reference model); the next downhill candidate completes normally.
